// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU core.
//
// Holds the A, D and PC registers and retires one instruction per clock
// unless stalled or in reset. The ALU is a separate module in this file.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; loads A=0, D=0, PC=RESET_PC
//   instruction  16-bit Hack instruction fetched at pc
//   inM          data-memory read value at addressM (combinational)
//   stall        when high, no register updates and no memory write
//   outM         ALU result (combinational)
//   writeM       data-memory write strobe for the current cycle
//   addressM     data-memory address, A[14:0] before the clock edge
//   pc           instruction-memory address

// Hack ALU: each control bit pre-conditions an operand or the result.
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = zx ? 16'h0000 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? 16'h0000 : y;
    y_n   = ny ? ~y_z : y_z;
    f_out = f ? (x_n + y_n) : (x_n & y_n);
    out   = no ? ~f_out : f_out;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end
endmodule

module hack_cpu #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  input  logic        stall,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);
  logic [15:0] a_reg, d_reg;
  logic [14:0] pc_reg;
  logic [15:0] a_next, d_next;
  logic [14:0] pc_next;

  logic [15:0] alu_y, alu_out;
  logic        alu_zr, alu_ng;
  logic        is_c, jmp;

  assign is_c  = instruction[15];
  // The 'a' bit selects memory or the A register as the second operand.
  assign alu_y = instruction[12] ? inM : a_reg;

  alu u_alu (
    .x  (d_reg),
    .y  (alu_y),
    .zx (instruction[11]),
    .nx (instruction[10]),
    .zy (instruction[9]),
    .ny (instruction[8]),
    .f  (instruction[7]),
    .no (instruction[6]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  // Jump bits select "negative", "zero" and "positive" outcomes.
  assign jmp = (instruction[2] & alu_ng) |
               (instruction[1] & alu_zr) |
               (instruction[0] & ~alu_ng & ~alu_zr);

  always_comb begin
    a_next  = a_reg;
    d_next  = d_reg;
    pc_next = pc_reg + 15'd1;  // natural 15-bit wrap
    if (!is_c) begin
      a_next = {1'b0, instruction[14:0]};
    end else begin
      if (instruction[5]) a_next = alu_out;
      if (instruction[4]) d_next = alu_out;
      // Jump target uses the A value from before this edge.
      if (jmp) pc_next = a_reg[14:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= RESET_PC;
    end else if (!stall) begin
      a_reg  <= a_next;
      d_reg  <= d_next;
      pc_reg <= pc_next;
    end
  end

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[3] & ~stall & ~reset;
  assign addressM = a_reg[14:0];
  assign pc       = pc_reg;
endmodule

// File: tb/tb_hack_cpu.sv
// Bench for hack_cpu: a directed table of cycle records followed by
// randomized instructions checked against a mnemonic-level Hack model.
module tb_hack_cpu;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic [15:0] instruction, inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM, pc;

  int n_vec = 0;
  int n_bad = 0;

  hack_cpu #(.RESET_PC(15'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .inM        (inM),
    .stall      (stall),
    .outM       (outM),
    .writeM     (writeM),
    .addressM   (addressM),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // One directed cycle: inputs plus the outputs expected before the edge.
  typedef struct {
    logic        rst;
    logic        stl;
    logic [15:0] ins;
    logic [14:0] exp_pc;
    logic [14:0] exp_addr;
    logic        exp_wm;
    logic        chk_out;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vt[21];

  // Standard Hack comp mnemonics: c-bits and the operation they name.
  typedef struct { logic [5:0] c; int op; } comp_t;
  comp_t comps[18];

  function automatic logic [15:0] ref_comp(int op, logic [15:0] d, logic [15:0] a);
    case (op)
      0:  return 16'd0;
      1:  return 16'd1;
      2:  return 16'hFFFF;
      3:  return d;
      4:  return a;
      5:  return ~d;
      6:  return ~a;
      7:  return 16'd0 - d;
      8:  return 16'd0 - a;
      9:  return d + 16'd1;
      10: return a + 16'd1;
      11: return d - 16'd1;
      12: return a - 16'd1;
      13: return d + a;
      14: return d - a;
      15: return a - d;
      16: return d & a;
      default: return d | a;
    endcase
  endfunction

  initial begin
    logic [15:0] m_a, m_d, r, y;
    logic [14:0] m_pc;
    logic        take;
    int          op;

    vt[0]  = '{0,0,16'h0005,15'd0,    15'd0,    0,0,16'h0000}; // @5, first cycle after reset
    vt[1]  = '{0,0,16'hEC10,15'd1,    15'd5,    0,1,16'h0005}; // D=A
    vt[2]  = '{0,0,16'hE7C8,15'd2,    15'd5,    1,1,16'h0006}; // M=D+1
    vt[3]  = '{0,0,16'hEA87,15'd3,    15'd5,    0,1,16'h0000}; // 0;JMP -> 5
    vt[4]  = '{0,0,16'hEA90,15'd5,    15'd5,    0,1,16'h0000}; // D=0
    vt[5]  = '{0,0,16'hE302,15'd6,    15'd5,    0,1,16'h0000}; // D;JEQ taken -> 5
    vt[6]  = '{0,0,16'h0007,15'd5,    15'd5,    0,0,16'h0000}; // @7
    vt[7]  = '{0,0,16'hEC10,15'd6,    15'd7,    0,1,16'h0007}; // D=A (7)
    vt[8]  = '{0,0,16'h0005,15'd7,    15'd7,    0,0,16'h0000}; // @5
    vt[9]  = '{0,0,16'hE302,15'd8,    15'd5,    0,1,16'h0007}; // D;JEQ not taken
    vt[10] = '{0,1,16'hE7C8,15'd9,    15'd5,    0,1,16'h0008}; // stalled
    vt[11] = '{0,1,16'hE7C8,15'd9,    15'd5,    0,1,16'h0008};
    vt[12] = '{0,1,16'hE7C8,15'd9,    15'd5,    0,1,16'h0008};
    vt[13] = '{0,0,16'hE7C8,15'd9,    15'd5,    1,1,16'h0008}; // stall released
    vt[14] = '{0,0,16'h7FFF,15'd10,   15'd5,    0,0,16'h0000}; // @32767
    vt[15] = '{0,0,16'hEA87,15'd11,   15'h7FFF, 0,1,16'h0000}; // 0;JMP -> 7FFF
    vt[16] = '{0,0,16'h0000,15'h7FFF, 15'h7FFF, 0,0,16'h0000}; // A-instr at 7FFF wraps
    vt[17] = '{0,0,16'h0003,15'd0,    15'd0,    0,0,16'h0000}; // @3
    vt[18] = '{1,0,16'hE7C8,15'd1,    15'd3,    0,1,16'h0008}; // reset mid-run, no write
    vt[19] = '{0,0,16'h0000,15'd0,    15'd0,    0,0,16'h0000}; // back at RESET_PC
    vt[20] = '{0,0,16'hE7C8,15'd1,    15'd0,    1,1,16'h0001}; // D cleared by reset

    comps[0]  = '{6'b101010, 0};  comps[1]  = '{6'b111111, 1};
    comps[2]  = '{6'b111010, 2};  comps[3]  = '{6'b001100, 3};
    comps[4]  = '{6'b110000, 4};  comps[5]  = '{6'b001101, 5};
    comps[6]  = '{6'b110001, 6};  comps[7]  = '{6'b001111, 7};
    comps[8]  = '{6'b110011, 8};  comps[9]  = '{6'b011111, 9};
    comps[10] = '{6'b110111, 10}; comps[11] = '{6'b001110, 11};
    comps[12] = '{6'b110010, 12}; comps[13] = '{6'b000010, 13};
    comps[14] = '{6'b010011, 14}; comps[15] = '{6'b000111, 15};
    comps[16] = '{6'b000000, 16}; comps[17] = '{6'b010101, 17};

    reset = 1'b1; stall = 1'b0; instruction = 16'h0000; inM = 16'h0000;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      reset = vt[i].rst; stall = vt[i].stl; instruction = vt[i].ins;
      @(negedge clk);
      check("pc", i, {1'b0, pc}, {1'b0, vt[i].exp_pc});
      check("addressM", i, {1'b0, addressM}, {1'b0, vt[i].exp_addr});
      check("writeM", i, {15'd0, writeM}, {15'd0, vt[i].exp_wm});
      if (vt[i].chk_out) check("outM", i, outM, vt[i].exp_out);
      @(posedge clk);
      #1;
    end

    // Randomized phase: resynchronise with a reset, then track a model.
    reset = 1'b1; stall = 1'b0; instruction = 16'h0000;
    @(posedge clk);
    #1;
    m_a = 16'h0000; m_d = 16'h0000; m_pc = 15'h0000;

    for (int i = 0; i < 2000; i++) begin
      op = 0;
      reset = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 7) == 0);
      inM   = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        instruction = {1'b0, 15'($urandom)};
      end else begin
        op = $urandom_range(0, 17);
        instruction = {1'b1, 2'($urandom), 1'($urandom), comps[op].c, 3'($urandom), 3'($urandom)};
        // Occasionally favour zero results so zero-based jumps get exercised.
        if ($urandom_range(0, 3) == 0) instruction[11:6] = 6'b101010;
        for (int k = 0; k < 18; k++) if (comps[k].c == instruction[11:6]) op = comps[k].op;
      end

      y = instruction[12] ? inM : m_a;
      r = ref_comp(op, m_d, y);
      take = instruction[15] && (
             (instruction[2] && $signed(r) < 0) ||
             (instruction[1] && r == 16'd0) ||
             (instruction[0] && $signed(r) > 0));

      @(negedge clk);
      check("rnd_pc", i, {1'b0, pc}, {1'b0, m_pc});
      check("rnd_addressM", i, {1'b0, addressM}, {1'b0, m_a[14:0]});
      check("rnd_writeM", i, {15'd0, writeM},
            {15'd0, instruction[15] && instruction[3] && !stall && !reset});
      if (instruction[15]) check("rnd_outM", i, outM, r);
      @(posedge clk);
      #1;

      if (reset) begin
        m_a = 16'h0000; m_d = 16'h0000; m_pc = 15'h0000;
      end else if (!stall) begin
        m_pc = take ? m_a[14:0] : 15'((int'(m_pc) + 1) % 32768);
        if (!instruction[15]) begin
          m_a = {1'b0, instruction[14:0]};
        end else begin
          if (instruction[4]) m_d = r;
          if (instruction[5]) m_a = r;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
